// File: rtl/bp_pkg.sv
// Shared constants, in-flight prediction record and counter seed values for the BTB predictor.
// Record PC fields are sized for the widest supported PC (32 bits); narrower PCs use the low bits.
package bp_pkg;
   localparam int BP_PC_W        = 8;
   localparam int BP_ENTRIES     = 16;
   localparam int BP_CTR_W       = 2;
   localparam int BP_RESOLVE_LAT = 2;
   localparam int BP_CNT_W       = 16;
   localparam int BP_PC_MAX      = 32;

   typedef logic [BP_PC_MAX-1:0] bp_pc_t;

   typedef struct packed {
      logic   vld;
      bp_pc_t pc;
      logic   pred_taken;
      bp_pc_t pred_target;
   } bp_rec_t;

   // Weakly not-taken: just below the taken threshold.
   function automatic int ctr_reset_val(input int ctr_w);
      return (1 << (ctr_w - 1)) - 1;
   endfunction

   // Weakly taken: a freshly allocated entry starts at the taken threshold.
   function automatic int ctr_alloc_val(input int ctr_w);
      return 1 << (ctr_w - 1);
   endfunction
endpackage

// File: rtl/bp_sat_counter.sv
// Next-value logic for a saturating up/down direction counter; load takes priority.
// Purely combinational, shared by the table update path.
module bp_sat_counter #(
   parameter int CTR_W = 2
) (
   input  logic [CTR_W-1:0] cnt_i,
   input  logic             inc_i,
   input  logic             dec_i,
   input  logic             load_i,
   input  logic [CTR_W-1:0] load_val_i,
   output logic [CTR_W-1:0] cnt_o
);
   localparam logic [CTR_W-1:0] CNT_MAX = '1;

   always_comb begin
      cnt_o = cnt_i;
      if (load_i) begin
         cnt_o = load_val_i;
      end else if (inc_i && cnt_i != CNT_MAX) begin
         cnt_o = cnt_i + CTR_W'(1);
      end else if (dec_i && cnt_i != '0) begin
         cnt_o = cnt_i - CTR_W'(1);
      end
   end
endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB + bimodal predictor: zero-latency lookup, RESOLVE_LAT-deep record pipe held by stall,
// registered one-cycle mispredict pulse with redirect PC, saturating branch/mispredict counters.
module branch_predictor_btb
   import bp_pkg::*;
#(
   parameter int PC_W        = BP_PC_W,
   parameter int ENTRIES     = BP_ENTRIES,
   parameter int CTR_W       = BP_CTR_W,
   parameter int RESOLVE_LAT = BP_RESOLVE_LAT,
   parameter int CNT_W       = BP_CNT_W
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            lookup_valid,
   input  logic [PC_W-1:0] lookup_pc,
   input  logic            stall,
   input  logic            flush,
   input  logic            resolve_valid,
   input  logic            resolve_taken,
   input  logic [PC_W-1:0] resolve_target,
   output logic            predict_taken,
   output logic [PC_W-1:0] predict_target,
   output logic            btb_hit,
   output logic            flush_out,
   output logic [PC_W-1:0] redirect_pc,
   output logic [CNT_W-1:0] branch_count,
   output logic [CNT_W-1:0] mispredict_count
);
   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = PC_W - IDX_W;
   localparam logic [CTR_W-1:0] CTR_RST   = CTR_W'(ctr_reset_val(CTR_W));
   localparam logic [CTR_W-1:0] CTR_ALLOC = CTR_W'(ctr_alloc_val(CTR_W));
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   logic [ENTRIES-1:0] vld_q;
   logic [TAG_W-1:0]   tag_q [ENTRIES];
   logic [PC_W-1:0]    tgt_q [ENTRIES];
   logic [CTR_W-1:0]   ctr_q [ENTRIES];
   bp_rec_t            rec_q [RESOLVE_LAT];
   logic               flush_q;
   logic [PC_W-1:0]    redirect_q;
   logic [CNT_W-1:0]   br_cnt_q, mis_cnt_q;

   logic [IDX_W-1:0] lk_idx, r_idx;
   logic [TAG_W-1:0] lk_tag, r_tag;
   logic [PC_W-1:0]  t_pc, t_tgt;
   logic             t_vld, t_pt, fire, act_taken, mis, upd, r_hit, ctr_wr;
   logic [CTR_W-1:0] ctr_nxt;
   bp_rec_t          rec_in;

   assign lk_idx         = lookup_pc[IDX_W-1:0];
   assign lk_tag         = lookup_pc[PC_W-1:IDX_W];
   assign btb_hit        = lookup_valid && vld_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
   assign predict_taken  = btb_hit && ctr_q[lk_idx][CTR_W-1];
   assign predict_target = predict_taken ? tgt_q[lk_idx] : lookup_pc + PC_W'(1);

   always_comb begin
      rec_in             = '0;
      rec_in.vld         = lookup_valid;
      rec_in.pc          = bp_pc_t'(lookup_pc);
      rec_in.pred_taken  = predict_taken;
      rec_in.pred_target = bp_pc_t'(predict_target);
   end

   assign t_vld = rec_q[RESOLVE_LAT-1].vld;
   assign t_pt  = rec_q[RESOLVE_LAT-1].pred_taken;
   assign t_pc  = rec_q[RESOLVE_LAT-1].pc[PC_W-1:0];
   assign t_tgt = rec_q[RESOLVE_LAT-1].pred_target[PC_W-1:0];

   // A missing resolve counts as "not taken", so a taken prediction with no branch still mispredicts.
   assign fire      = !stall && t_vld;
   assign act_taken = resolve_valid && resolve_taken;
   assign mis       = fire && ((t_pt != act_taken) || (act_taken && t_tgt != resolve_target));
   assign upd       = fire && resolve_valid;

   assign r_idx  = t_pc[IDX_W-1:0];
   assign r_tag  = t_pc[PC_W-1:IDX_W];
   assign r_hit  = vld_q[r_idx] && (tag_q[r_idx] == r_tag);
   assign ctr_wr = upd && (r_hit || resolve_taken);

   bp_sat_counter #(.CTR_W(CTR_W)) u_ctr (
      .cnt_i      (ctr_q[r_idx]),
      .inc_i      (resolve_taken),
      .dec_i      (!resolve_taken),
      .load_i     (!r_hit),
      .load_val_i (CTR_ALLOC),
      .cnt_o      (ctr_nxt)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vld_q      <= '0;
         flush_q    <= 1'b0;
         redirect_q <= '0;
         br_cnt_q   <= '0;
         mis_cnt_q  <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            tag_q[i] <= '0;
            tgt_q[i] <= '0;
            ctr_q[i] <= CTR_RST;
         end
         for (int i = 0; i < RESOLVE_LAT; i++) rec_q[i] <= '0;
      end else begin
         if (flush || flush_q) begin
            for (int i = 0; i < RESOLVE_LAT; i++) rec_q[i].vld <= 1'b0;
         end else if (!stall) begin
            rec_q[0] <= rec_in;
            for (int i = 1; i < RESOLVE_LAT; i++) rec_q[i] <= rec_q[i-1];
         end
         flush_q <= mis;
         if (mis) redirect_q <= act_taken ? resolve_target : t_pc + PC_W'(1);
         if (upd && br_cnt_q != CNT_MAX) br_cnt_q <= br_cnt_q + CNT_W'(1);
         if (mis && mis_cnt_q != CNT_MAX) mis_cnt_q <= mis_cnt_q + CNT_W'(1);
         if (ctr_wr) begin
            vld_q[r_idx] <= 1'b1;
            tag_q[r_idx] <= r_tag;
            ctr_q[r_idx] <= ctr_nxt;
            if (resolve_taken) tgt_q[r_idx] <= resolve_target;
         end
      end
   end

   assign flush_out        = flush_q;
   assign redirect_pc      = redirect_q;
   assign branch_count     = br_cnt_q;
   assign mispredict_count = mis_cnt_q;
endmodule

// File: tb/tb_branch_predictor_btb.sv
// Randomized and directed bench against a table/queue reference model; a second instance with
// 4-bit performance counters exercises counter saturation in a short run.
module tb_branch_predictor_btb;
   localparam int PC_W = 8, ENT = 16, CTR_W = 2, LAT = 2, CNT_W = 16, CNT_S = 4;
   localparam int PC_MOD  = 1 << PC_W;
   localparam int CTR_MAX = (1 << CTR_W) - 1;

   logic            clk = 1'b0;
   logic            reset;
   logic            lookup_valid, stall, flush, resolve_valid, resolve_taken;
   logic [PC_W-1:0] lookup_pc, resolve_target;
   logic            predict_taken, btb_hit, flush_out;
   logic [PC_W-1:0] predict_target, redirect_pc;
   logic [CNT_W-1:0] branch_count, mispredict_count;
   logic            s_predict_taken, s_btb_hit, s_flush_out;
   logic [PC_W-1:0] s_predict_target, s_redirect_pc;
   logic [CNT_S-1:0] s_branch_count, s_mispredict_count;

   always #5 clk = ~clk;

   branch_predictor_btb #(.PC_W(PC_W), .ENTRIES(ENT), .CTR_W(CTR_W), .RESOLVE_LAT(LAT), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .lookup_valid(lookup_valid), .lookup_pc(lookup_pc), .stall(stall),
      .flush(flush), .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
      .resolve_target(resolve_target), .predict_taken(predict_taken), .predict_target(predict_target),
      .btb_hit(btb_hit), .flush_out(flush_out), .redirect_pc(redirect_pc),
      .branch_count(branch_count), .mispredict_count(mispredict_count));

   branch_predictor_btb #(.PC_W(PC_W), .ENTRIES(ENT), .CTR_W(CTR_W), .RESOLVE_LAT(LAT), .CNT_W(CNT_S)) dut_s (
      .clk(clk), .reset(reset), .lookup_valid(lookup_valid), .lookup_pc(lookup_pc), .stall(stall),
      .flush(flush), .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
      .resolve_target(resolve_target), .predict_taken(s_predict_taken), .predict_target(s_predict_target),
      .btb_hit(s_btb_hit), .flush_out(s_flush_out), .redirect_pc(s_redirect_pc),
      .branch_count(s_branch_count), .mispredict_count(s_mispredict_count));

   int total = 0;
   int bad   = 0;

   task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {
      bit            v;
      bit [PC_W-1:0] pc;
      bit            pt;
      bit [PC_W-1:0] ptg;
   } rec_s;

   bit     m_vld [ENT];
   int     m_tag [ENT];
   int     m_tgt [ENT];
   int     m_ctr [ENT];
   rec_s   pipe [$];          // pipe[0] youngest, pipe[LAT-1] oldest
   bit     m_flush;
   int     m_redir;
   longint m_br, m_mis;

   function automatic longint sat(input longint v, input int w);
      longint mx = (longint'(1) << w) - 1;
      return (v > mx) ? mx : v;
   endfunction

   function automatic void m_reset();
      for (int i = 0; i < ENT; i++) begin
         m_vld[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = (1 << (CTR_W - 1)) - 1;
      end
      pipe.delete();
      for (int i = 0; i < LAT; i++) pipe.push_back('0);
      m_flush = 0; m_redir = 0; m_br = 0; m_mis = 0;
   endfunction

   function automatic void m_predict(input int pc, input bit lv, output bit hit, output bit tk, output int tgt);
      int i = pc % ENT;
      hit = lv && m_vld[i] && (m_tag[i] == pc / ENT);
      tk  = hit && (m_ctr[i] >= (1 << (CTR_W - 1)));
      tgt = tk ? m_tgt[i] : (pc + 1) % PC_MOD;
   endfunction

   function automatic void m_step(input bit lv, input int pc, input bit st, input bit fl,
                                  input bit rv, input bit rt, input int rtg);
      bit hit, tk, fire, at, mis;
      int tg, i, tpc;
      rec_s nr, tail;
      m_predict(pc, lv, hit, tk, tg);
      nr.v = lv; nr.pc = PC_W'(pc); nr.pt = tk; nr.ptg = PC_W'(tg);
      tail = pipe[LAT-1];
      tpc  = int'(tail.pc);
      fire = !st && tail.v;
      at   = rv && rt;
      mis  = fire && ((tail.pt != at) || (at && int'(tail.ptg) != rtg));
      if (mis) begin
         m_mis++;
         m_redir = at ? rtg : (tpc + 1) % PC_MOD;
      end
      if (fire && rv) begin
         m_br++;
         i = tpc % ENT;
         if (m_vld[i] && m_tag[i] == tpc / ENT) begin
            if (rt) begin
               m_ctr[i] = (m_ctr[i] < CTR_MAX) ? m_ctr[i] + 1 : CTR_MAX;
               m_tgt[i] = rtg;
            end else begin
               m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
            end
         end else if (rt) begin
            m_vld[i] = 1; m_tag[i] = tpc / ENT; m_tgt[i] = rtg; m_ctr[i] = 1 << (CTR_W - 1);
         end
      end
      if (fl || m_flush) begin
         for (int k = 0; k < LAT; k++) begin
            rec_s r = pipe[k];
            r.v = 0;
            pipe[k] = r;
         end
      end else if (!st) begin
         pipe.push_front(nr);
         void'(pipe.pop_back());
      end
      m_flush = mis;
   endfunction

   // One clock: drive at negedge, check outputs mid-cycle, then advance the model past the edge.
   task automatic cyc(input bit rst, input bit lv, input int pc, input bit st, input bit fl,
                      input bit rv, input bit rt, input int rtg);
      bit hit, tk;
      int tg;
      @(negedge clk);
      reset = rst; lookup_valid = lv; lookup_pc = PC_W'(pc); stall = st; flush = fl;
      resolve_valid = rv; resolve_taken = rt; resolve_target = PC_W'(rtg);
      #1;
      if (!rst) m_reset();
      m_predict(pc, lv, hit, tk, tg);
      chk_eq("btb_hit", btb_hit, hit);
      chk_eq("predict_taken", predict_taken, tk);
      chk_eq("predict_target", predict_target, tg);
      chk_eq("flush_out", flush_out, m_flush);
      if (m_flush) chk_eq("redirect_pc", redirect_pc, m_redir);
      chk_eq("branch_count", branch_count, sat(m_br, CNT_W));
      chk_eq("mispredict_count", mispredict_count, sat(m_mis, CNT_W));
      chk_eq("s_branch_count", s_branch_count, sat(m_br, CNT_S));
      chk_eq("s_mispredict_count", s_mispredict_count, sat(m_mis, CNT_S));
      if (rst) m_step(lv, pc, st, fl, rv, rt, rtg);
   endtask

   task automatic idle(input bit rv, input bit rt, input int rtg);
      cyc(1, 0, 0, 0, 0, rv, rt, rtg);
   endtask

   // Lookup, wait, resolve, then one cycle where any mispredict pulse is visible.
   task automatic br(input int pc, input bit rt, input int rtg);
      cyc(1, 1, pc, 0, 0, 0, 0, 0);
      idle(0, 0, 0);
      idle(1, rt, rtg);
      idle(0, 0, 0);
   endtask

   // Lookup whose record is discarded by a same-cycle flush, so it only observes the table.
   task automatic probe(input int pc);
      cyc(1, 1, pc, 0, 1, 0, 0, 0);
   endtask

   initial begin
      reset = 0; lookup_valid = 0; lookup_pc = '0; stall = 0; flush = 0;
      resolve_valid = 0; resolve_taken = 0; resolve_target = '0;
      m_reset();
      cyc(0, 1, 'h05, 0, 0, 0, 0, 0);
      chk_eq("rst_target", predict_target, 'h06);
      chk_eq("rst_redirect", redirect_pc, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0);

      // Cold lookup, then cold taken resolve allocates and mispredicts.
      cyc(1, 1, 'h05, 0, 0, 0, 0, 0);
      chk_eq("cold_hit", btb_hit, 0);
      chk_eq("cold_target", predict_target, 'h06);
      idle(0, 0, 0);
      idle(1, 1, 'h20);
      cyc(1, 1, 'h05, 0, 0, 0, 0, 0);
      chk_eq("cold_flush", flush_out, 1);
      chk_eq("cold_redirect", redirect_pc, 'h20);
      chk_eq("alloc_hit", btb_hit, 1);
      chk_eq("alloc_taken", predict_taken, 1);
      chk_eq("alloc_target", predict_target, 'h20);
      idle(0, 0, 0);
      chk_eq("pulse_one_cycle", flush_out, 0);

      // Counter climbs to saturation; a single not-taken leaves it predicting taken.
      for (int k = 0; k < 4; k++) br('h05, 1, 'h20);
      br('h05, 0, 0);
      probe('h05);
      chk_eq("hyst_taken", predict_taken, 1);
      chk_eq("hyst_branches", branch_count, 6);
      chk_eq("hyst_mispredicts", mispredict_count, 2);

      // Alias on the same index replaces the entry.
      probe('h15);
      chk_eq("alias_miss", btb_hit, 0);
      br('h15, 1, 'h40);
      probe('h05);
      chk_eq("alias_evicted", btb_hit, 0);
      probe('h15);
      chk_eq("alias_hit", btb_hit, 1);

      // Stall holds a pending resolution; release resolves exactly once.
      cyc(1, 1, 'h15, 0, 0, 0, 0, 0);
      idle(0, 0, 0);
      for (int k = 0; k < 3; k++) begin
         cyc(1, 0, 0, 1, 0, 1, 0, 0);
         chk_eq("stall_no_flush", flush_out, 0);
      end
      idle(1, 0, 0);
      idle(0, 0, 0);
      chk_eq("release_flush", flush_out, 1);
      chk_eq("release_redirect", redirect_pc, 'h16);
      idle(0, 0, 0);
      chk_eq("release_once", branch_count, 8);

      // Flush alongside a lookup discards it.
      cyc(1, 1, 'h15, 0, 1, 0, 0, 0);
      for (int k = 0; k < 3; k++) idle(1, 1, 'h40);
      chk_eq("flushed_no_resolve", branch_count, 8);

      // PC wrap, then drive the narrow counters into saturation.
      probe('hFF);
      chk_eq("wrap_target", predict_target, 'h00);
      for (int k = 0; k < 20; k++) br('h15, 1, (k % 2 != 0) ? 'h41 : 'h40);
      idle(0, 0, 0);
      chk_eq("sat_mispredicts", s_mispredict_count, 15);
      chk_eq("sat_branches", s_branch_count, 15);
      chk_eq("wide_mispredicts", mispredict_count, 24);

      // Reset asserted while a resolution is pending suppresses it.
      cyc(1, 1, 'h15, 0, 0, 0, 0, 0);
      idle(0, 0, 0);
      cyc(0, 0, 0, 0, 0, 1, 0, 0);
      idle(0, 0, 0);
      chk_eq("rst_mid_flush", flush_out, 0);
      chk_eq("rst_mid_count", branch_count, 0);

      for (int n = 0; n < 4000; n++) begin
         int pc, rtg;
         pc  = ($urandom_range(0, 7) == 0) ? 'hFF : (($urandom_range(0, 3) << 4) | $urandom_range(4, 6));
         rtg = ($urandom_range(0, 3) << 4) | 1;
         cyc(($urandom_range(0, 599) != 0), ($urandom_range(0, 3) != 0), pc,
             ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0),
             ($urandom_range(0, 3) != 0), $urandom_range(0, 1) != 0, rtg);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/branch_predictor_btb.md
BRANCH_PREDICTOR_BTB -- requirements
Module: branch_predictor_btb

Interface
REQ-001 SHALL have parameter PC_W, default 8, meaning PC width in bits.
REQ-002 SHALL have parameter ENTRIES, default 16, meaning BTB/BHT entries (power of 2, IDX_W = log2(ENTRIES), IDX_W < PC_W).
REQ-003 SHALL have parameter CTR_W, default 2, meaning saturating direction-counter width (>= 1).
REQ-004 SHALL have parameter RESOLVE_LAT, default 2, meaning cycles from lookup to resolve (>= 1).
REQ-005 SHALL have parameter CNT_W, default 16, meaning performance-counter width.
REQ-006 clk  input  1  sole clock, rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 lookup_valid  input  1  fetch presents a PC this cycle.
REQ-009 lookup_pc  input  PC_W  fetch PC.
REQ-010 stall  input  1  hold the prediction pipeline.
REQ-011 flush  input  1  external flush; clear in-flight predictions.
REQ-012 resolve_valid  input  1  EX stage holds a resolved branch/jump.
REQ-013 resolve_taken  input  1  actual direction.
REQ-014 resolve_target  input  PC_W  actual target.
REQ-015 predict_taken  output  1  combinational taken prediction for lookup_pc.
REQ-016 predict_target  output  PC_W  next fetch PC (BTB target if taken, else lookup_pc+1 mod 2^PC_W).
REQ-017 btb_hit  output  1  valid entry with matching tag.
REQ-018 flush_out  output  1  registered one-cycle mispredict pulse.
REQ-019 redirect_pc  output  PC_W  registered correct fetch PC, meaningful when flush_out=1.
REQ-020 branch_count, mispredict_count  output  CNT_W each  performance counters.

Function
REQ-021 Entry SHALL hold valid, tag = pc[PC_W-1:IDX_W], target, counter; index = pc[IDX_W-1:0].
REQ-022 btb_hit SHALL equal lookup_valid AND entry.valid AND tag match; predict_taken SHALL equal btb_hit AND counter MSB; lookup is combinational, zero latency.
REQ-023 A RESOLVE_LAT-deep record pipeline SHALL carry {valid, pc, pred_taken, pred_target}; enters with valid=lookup_valid; advances only when stall=0.
REQ-024 flush=1 or flush_out=1 SHALL clear every record valid bit at the next edge, overriding stall.
REQ-025 Resolution SHALL occur at an edge with stall=0 and tail record valid; resolve_valid with invalid tail SHALL be ignored (no update, no count).
REQ-026 Mispredict: resolve_valid and (pred_taken != resolve_taken, or both taken and pred_target != resolve_target); also resolve_valid=0 with pred_taken=1.
REQ-027 On mispredict flush_out SHALL be 1 for exactly the next cycle; redirect_pc = resolve_target if taken, else tail pc+1 mod 2^PC_W.
REQ-028 On resolve_valid with hit: counter +1 if taken, -1 if not, saturating at 2^CTR_W-1 and 0; target overwritten when taken.
REQ-029 On resolve_valid, miss and taken: allocate (replace) entry, valid=1, tag, target, counter = 2^(CTR_W-1) (weakly taken); miss and not taken: no allocation.
REQ-030 Table write SHALL take effect at the edge; same-cycle lookup of the same index SHALL see the old contents.
REQ-031 branch_count SHALL increment per accepted resolve_valid; mispredict_count per REQ-026 event; both saturate at 2^CNT_W-1.

Reset
REQ-032 While reset=0: all entry valid=0, counters = 2^(CTR_W-1)-1 (weakly not-taken), targets/tags 0, records cleared, flush_out=0, redirect_pc=0, both perf counters 0; asserted mid-resolve it SHALL suppress that update and pulse.
REQ-033 Outputs predict_taken=0, btb_hit=0, predict_target=lookup_pc+1 during reset, table being empty.

Structure
REQ-034 Package bp_pkg SHALL hold default parameter constants, the prediction-record struct type, and the counter-reset/allocate constant functions.
REQ-035 One sub-module bp_sat_counter (CTR_W param, inc/dec/load, saturating) SHALL be instantiated per entry or as shared update logic.

Verification (PC_W=8, ENTRIES=16, CTR_W=2, RESOLVE_LAT=2)
REQ-036 Reset, lookup pc=0x05 -> btb_hit=0, predict_taken=0, predict_target=0x06, counters 0.
REQ-037 Resolve pc=0x05 taken target 0x20 (cold) -> flush_out pulse 1 cycle, redirect_pc=0x20; next lookup 0x05 -> hit, taken, target 0x20.
REQ-038 Four taken resolves at 0x05 then one not-taken -> counter 3 then 2, still predicts taken, one flush_out only on the not-taken.
REQ-039 Alias 0x15 vs 0x05 (same index, tag differs) -> miss on 0x15; taken resolve of 0x15 replaces entry; 0x05 then misses.
REQ-040 stall=1 held 3 cycles with resolve_valid=1 -> no update, no flush_out; release -> exactly one resolution; flush=1 same cycle as lookup -> record discarded, no later resolution.
REQ-041 Wrap: lookup 0xFF miss -> predict_target=0x00; force 2^16 mispredicts -> mispredict_count holds 0xFFFF.
